// File: rtl/pid_cfg_pkg.sv
// Shared definitions for the PID register-config writer.
//  - SYNC_BYTE  : frame start marker
//  - CMD_SEL_Q  : bit of the CMD byte that selects the q-axis PID
//  - cfg_state_e: frame parser states
//  - cfg_err_e  : cause of a rejected frame (debug visibility)
//  - chk_fold   : running XOR checksum helper
package pid_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CMD_SEL_Q = 0;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    COMMIT = 3'd5
  } cfg_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CMD     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } cfg_err_e;

  // Fold one more byte into the frame checksum.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/pid_cfg_writer_timer.sv
// cfg_frame_timer: inter-byte watchdog for the config frame parser.
// Ports:
//  clk, rstb  clock, asynchronous active-low reset
//  clear      zero the counter (has priority over enable)
//  enable     count one cycle
//  expire     high while enabled and this is the TIMEOUT_CYCLES-th cycle
//             since the last clear
module cfg_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_r;

  // Idle-cycle counter; saturates so a stuck enable can never wrap back to 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != CNT_W'(TIMEOUT_CYCLES))) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // count_r holds the number of elapsed idle cycles before this edge.
  assign expire = enable && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pid_cfg_writer.sv
// pid_cfg_writer: parses ECU config frames from a valid/ready byte stream and
// turns each good frame into one single-cycle register write to pid_d or pid_q.
// Frame: A5, CMD, ADDR (NB bytes MSB first), DATA (NB bytes MSB first),
//        CHK = XOR of CMD/ADDR/DATA bytes.
// Ports:
//  clk, rstb               clock, asynchronous active-low reset
//  rx_data/rx_valid/rx_ready  config byte stream (accept on valid && ready)
//  loop_idle               FOC sequencer idle; writes wait for it
//  pid_{d,q}_wen           one-cycle write strobes (never both)
//  pid_{d,q}_addr/_data    last committed address/data (shared value)
//  frame_ok                pulse with the write strobe
//  frame_err               pulse on bad cmd, bad checksum or timeout
//  err_count               saturating error count
// D_WIDTH must be a multiple of 8.
import pid_cfg_pkg::*;

module pid_cfg_writer #(
  parameter int D_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               loop_idle,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_d_addr,
  output logic [D_WIDTH-1:0] pid_q_addr,
  output logic [D_WIDTH-1:0] pid_d_data,
  output logic [D_WIDTH-1:0] pid_q_data,
  output logic               frame_ok,
  output logic               frame_err,
  output logic [7:0]         err_count
);

  localparam int NB   = D_WIDTH / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  cfg_state_e         state_r;
  cfg_state_e         state_next_s;
  cfg_err_e           err_cause_s;
  logic               acc_s;
  logic               err_s;
  logic               commit_s;
  logic               last_byte_s;
  logic               tmr_en_s;
  logic               tmr_clr_s;
  logic               expire_s;

  logic               sel_r;
  logic [7:0]         chk_r;
  logic [BC_W-1:0]    byte_cnt_r;
  logic [D_WIDTH-1:0] addr_sh_r;
  logic [D_WIDTH-1:0] data_sh_r;
  logic [D_WIDTH-1:0] addr_shift_s;
  logic [D_WIDTH-1:0] data_shift_s;

  logic               rx_ready_r;
  logic               pid_d_wen_r;
  logic               pid_q_wen_r;
  logic [D_WIDTH-1:0] addr_out_r;
  logic [D_WIDTH-1:0] data_out_r;
  logic               frame_ok_r;
  logic               frame_err_r;
  logic [7:0]         err_count_r;

  assign acc_s       = rx_valid && rx_ready_r;
  assign last_byte_s = (byte_cnt_r == BC_W'(NB - 1));
  assign err_s       = (err_cause_s != ERR_NONE);

  // MSB-first field assembly; an 8-bit field is just the byte itself.
  generate
    if (NB == 1) begin : g_nb1
      assign addr_shift_s = rx_data;
      assign data_shift_s = rx_data;
    end else begin : g_nbn
      assign addr_shift_s = {addr_sh_r[D_WIDTH-9:0], rx_data};
      assign data_shift_s = {data_sh_r[D_WIDTH-9:0], rx_data};
    end
  endgenerate

  // The watchdog only runs while a frame is partially received.
  assign tmr_en_s  = (state_r == CMD) || (state_r == ADDR) ||
                     (state_r == DATA) || (state_r == CHK);
  assign tmr_clr_s = acc_s || (state_next_s == HUNT);

  cfg_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstb   (rstb),
    .clear  (tmr_clr_s),
    .enable (tmr_en_s),
    .expire (expire_s)
  );

  // Parser state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an accepted byte always takes precedence over expiry.
  always_comb begin
    state_next_s = state_r;
    err_cause_s  = ERR_NONE;
    commit_s     = 1'b0;
    case (state_r)
      HUNT: begin
        if (acc_s && (rx_data == SYNC_BYTE)) begin
          state_next_s = CMD;
        end else begin
          state_next_s = HUNT;
        end
      end
      CMD: begin
        if (acc_s) begin
          if (rx_data[7:1] != 7'd0) begin
            state_next_s = HUNT;
            err_cause_s  = ERR_CMD;
          end else begin
            state_next_s = ADDR;
          end
        end else if (expire_s) begin
          state_next_s = HUNT;
          err_cause_s  = ERR_TIMEOUT;
        end else begin
          state_next_s = CMD;
        end
      end
      ADDR: begin
        if (acc_s) begin
          if (last_byte_s) begin
            state_next_s = DATA;
          end else begin
            state_next_s = ADDR;
          end
        end else if (expire_s) begin
          state_next_s = HUNT;
          err_cause_s  = ERR_TIMEOUT;
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        if (acc_s) begin
          if (last_byte_s) begin
            state_next_s = CHK;
          end else begin
            state_next_s = DATA;
          end
        end else if (expire_s) begin
          state_next_s = HUNT;
          err_cause_s  = ERR_TIMEOUT;
        end else begin
          state_next_s = DATA;
        end
      end
      CHK: begin
        if (acc_s) begin
          if (rx_data == chk_r) begin
            state_next_s = COMMIT;
          end else begin
            state_next_s = HUNT;
            err_cause_s  = ERR_CHK;
          end
        end else if (expire_s) begin
          state_next_s = HUNT;
          err_cause_s  = ERR_TIMEOUT;
        end else begin
          state_next_s = CHK;
        end
      end
      COMMIT: begin
        if (loop_idle) begin
          commit_s     = 1'b1;
          state_next_s = HUNT;
        end else begin
          state_next_s = COMMIT;
        end
      end
      default: begin
        state_next_s = HUNT;
      end
    endcase
  end

  // Frame capture: target select, field shift registers and checksum.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sel_r      <= 1'b0;
      chk_r      <= 8'd0;
      byte_cnt_r <= '0;
      addr_sh_r  <= '0;
      data_sh_r  <= '0;
    end else begin
      case (state_r)
        CMD: begin
          if (acc_s) begin
            sel_r      <= rx_data[CMD_SEL_Q];
            chk_r      <= rx_data;
            byte_cnt_r <= '0;
          end
        end
        ADDR: begin
          if (acc_s) begin
            addr_sh_r  <= addr_shift_s;
            chk_r      <= chk_fold(chk_r, rx_data);
            byte_cnt_r <= last_byte_s ? '0 : byte_cnt_r + BC_W'(1);
          end
        end
        DATA: begin
          if (acc_s) begin
            data_sh_r  <= data_shift_s;
            chk_r      <= chk_fold(chk_r, rx_data);
            byte_cnt_r <= last_byte_s ? '0 : byte_cnt_r + BC_W'(1);
          end
        end
        default: begin
          byte_cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered outputs: strobes, committed addr/data, status and error count.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_ready_r  <= 1'b1;
      pid_d_wen_r <= 1'b0;
      pid_q_wen_r <= 1'b0;
      addr_out_r  <= '0;
      data_out_r  <= '0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      rx_ready_r  <= (state_next_s != COMMIT);
      pid_d_wen_r <= commit_s && !sel_r;
      pid_q_wen_r <= commit_s && sel_r;
      frame_ok_r  <= commit_s;
      frame_err_r <= err_s;
      if (commit_s) begin
        addr_out_r <= addr_sh_r;
        data_out_r <= data_sh_r;
      end
      if (err_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign rx_ready   = rx_ready_r;
  assign pid_d_wen  = pid_d_wen_r;
  assign pid_q_wen  = pid_q_wen_r;
  assign pid_d_addr = addr_out_r;
  assign pid_q_addr = addr_out_r;
  assign pid_d_data = data_out_r;
  assign pid_q_data = data_out_r;
  assign frame_ok   = frame_ok_r;
  assign frame_err  = frame_err_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_pid_cfg_writer.sv
// Self-checking bench for pid_cfg_writer (D_WIDTH = 16): directed frames plus
// randomized frames compared against a frame-level reference model.
module tb_pid_cfg_writer;

  localparam int DW = 16;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          loop_idle = 1'b1;
  logic          rx_ready;
  logic          pid_d_wen, pid_q_wen;
  logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
  logic          frame_ok, frame_err;
  logic [7:0]    err_count;

  pid_cfg_writer #(.D_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .loop_idle(loop_idle),
    .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
    .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
    .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  // model state: last committed register write and number of frame errors
  logic [DW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_errs = 0;

  typedef struct {
    logic          dw, qw, ok, err;
    logic [DW-1:0] ad, aq, dd, dq;
    int            at;
  } ev_t;
  ev_t ev_q[$];
  logic [7:0] fq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (rstb && (pid_d_wen || pid_q_wen || frame_ok || frame_err)) begin
      ev_t e;
      e.dw = pid_d_wen; e.qw = pid_q_wen; e.ok = frame_ok; e.err = frame_err;
      e.ad = pid_d_addr; e.aq = pid_q_addr; e.dd = pid_d_data; e.dq = pid_q_data;
      e.at = cyc;
      ev_q.push_back(e);
    end
  end

  function automatic int exp_cnt();
    return (m_errs > 255) ? 255 : m_errs;
  endfunction

  task automatic check_hold(input string tag);
    check_eq({tag, "_d_addr"}, pid_d_addr, m_addr);
    check_eq({tag, "_q_addr"}, pid_q_addr, m_addr);
    check_eq({tag, "_d_data"}, pid_d_data, m_data);
    check_eq({tag, "_q_data"}, pid_q_data, m_data);
    check_eq({tag, "_err_count"}, err_count, exp_cnt());
  endtask

  // send one byte after 'gap' idle cycles; leaves us at the negedge after accept
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    budget = 500;
    while (!rx_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!rx_ready) check_eq("rx_ready_wait", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic build(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] d,
                       input logic [7:0] flip);
    logic [7:0] x;
    fq = {8'hA5, cmd, a[15:8], a[7:0], d[15:8], d[7:0]};
    x = 8'd0;
    for (int i = 1; i < 6; i++) x = x ^ fq[i];
    fq.push_back(x ^ flip);
  endtask

  task automatic send_frame(input int maxgap);
    foreach (fq[i]) send_byte(fq[i], $urandom_range(0, maxgap));
  endtask

  task automatic wait_event(input int budget, output bit got);
    while (ev_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    got = (ev_q.size() != 0);
    if (!got) check_eq("event_timeout", ev_q.size(), 1);
  endtask

  task automatic expect_write(input string tag, input logic sel, input logic [15:0] a,
                              input logic [15:0] d, input int at_exp);
    bit  got;
    ev_t e;
    wait_event(100, got);
    if (got) begin
      e = ev_q.pop_front();
      check_eq({tag, "_d_wen"}, e.dw, !sel);
      check_eq({tag, "_q_wen"}, e.qw, sel);
      check_eq({tag, "_frame_ok"}, e.ok, 1);
      check_eq({tag, "_frame_err"}, e.err, 0);
      check_eq({tag, "_ev_d_addr"}, e.ad, a);
      check_eq({tag, "_ev_q_addr"}, e.aq, a);
      check_eq({tag, "_ev_d_data"}, e.dd, d);
      check_eq({tag, "_ev_q_data"}, e.dq, d);
      check_eq({tag, "_latency"}, e.at, at_exp);
    end
    m_addr = a;
    m_data = d;
    repeat (2) @(negedge clk);
    check_eq({tag, "_extra_events"}, ev_q.size(), 0);
    ev_q.delete();
    check_hold(tag);
  endtask

  task automatic expect_err(input string tag, input int budget, input int at_exp);
    bit  got;
    ev_t e;
    wait_event(budget, got);
    m_errs++;
    if (got) begin
      e = ev_q.pop_front();
      check_eq({tag, "_frame_err"}, e.err, 1);
      check_eq({tag, "_wen"}, {e.dw, e.qw, e.ok}, 3'b000);
      if (at_exp >= 0) check_eq({tag, "_err_time"}, e.at, at_exp);
    end
    repeat (2) @(negedge clk);
    check_eq({tag, "_extra_events"}, ev_q.size(), 0);
    ev_q.delete();
    check_hold(tag);
  endtask

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0]  cmd, g, flip;
    logic [15:0] a, d;
    logic        sel;
    int          kind, rdy_hi, rise, r;

    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_strobes", {pid_d_wen, pid_q_wen, frame_ok, frame_err}, 4'b0000);
    check_hold("rst");

    // directed: d write, q write, bad checksum
    build(8'h00, 16'h0003, 16'h1234, 8'h00);
    check_eq("vec1_chk_byte", fq[6], 8'h25);
    send_frame(0);
    expect_write("vec1", 1'b0, 16'h0003, 16'h1234, last_acc + 1);
    fq = {8'hA5, 8'h01, 8'h00, 8'h01, 8'hFF, 8'hFE, 8'h01};
    send_frame(2);
    expect_write("vec2", 1'b1, 16'h0001, 16'hFFFE, last_acc + 1);
    fq = {8'hA5, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'h24};
    send_frame(1);
    expect_err("badchk", 20, -1);

    // commit held off by loop_idle = 0
    loop_idle = 1'b0;
    build(8'h01, 16'h00A5, 16'h5AA5, 8'h00);
    send_frame(1);
    rdy_hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (rx_ready) rdy_hi++;
    end
    check_eq("commit_backpressure", rdy_hi, 0);
    check_eq("commit_no_event", ev_q.size(), 0);
    check_hold("commit_wait");
    loop_idle = 1'b1;
    rise = cyc;
    expect_write("commit_release", 1'b1, 16'h00A5, 16'h5AA5, rise + 1);

    // timeout after A5 00 00, then a full frame still goes through
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    expect_err("timeout", TO + 50, last_acc + TO);
    build(8'h00, 16'h0042, 16'hBEEF, 8'h00);
    send_frame(1);
    expect_write("after_timeout", 1'b0, 16'h0042, 16'hBEEF, last_acc + 1);

    // garbage 11 A5 02, then a valid frame
    send_byte(8'h11, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    expect_err("badcmd", 20, -1);
    build(8'h01, 16'h7777, 16'h0102, 8'h00);
    send_frame(0);
    expect_write("after_badcmd", 1'b1, 16'h7777, 16'h0102, last_acc + 1);

    // byte accepted on the very edge the timeout would fire: accept wins
    build(8'h00, 16'h1357, 16'h2468, 8'h00);
    foreach (fq[i]) send_byte(fq[i], (i == 3) ? TO - 1 : 0);
    expect_write("timeout_edge", 1'b0, 16'h1357, 16'h2468, last_acc + 1);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, $urandom_range(0, 2));
      end
      kind = $urandom_range(0, 9);
      sel = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 16'hA5A5 : 16'($urandom);
      if (kind < 6) begin
        build({7'd0, sel}, a, d, 8'h00);
        send_frame(3);
        expect_write("rnd_write", sel, a, d, last_acc + 1);
      end else if (kind < 8) begin
        flip = 8'($urandom_range(1, 255));
        build({7'd0, sel}, a, d, flip);
        send_frame(3);
        expect_err("rnd_badchk", 20, -1);
      end else begin
        cmd = 8'(($urandom_range(1, 127) << 1) | sel);
        send_byte(8'hA5, $urandom_range(0, 3));
        send_byte(cmd, $urandom_range(0, 3));
        expect_err("rnd_badcmd", 20, -1);
      end
    end

    // err_count saturation: errors past 255 still pulse frame_err
    while (m_errs < 258) begin
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      expect_err("sat", 20, -1);
    end

    // reset while waiting in COMMIT: no write may come out
    loop_idle = 1'b0;
    build(8'h01, 16'hCAFE, 16'hF00D, 8'h00);
    send_frame(0);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    m_addr = '0;
    m_data = '0;
    m_errs = 0;
    check_eq("async_rst_rx_ready", rx_ready, 1);
    check_hold("async_rst");
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    loop_idle = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst_no_write", ev_q.size(), 0);
    check_hold("post_rst");
    build(8'h00, 16'h0009, 16'h0900, 8'h00);
    send_frame(1);
    expect_write("post_rst_write", 1'b0, 16'h0009, 16'h0900, last_acc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
